// File: rtl/pipeline_ctrl.sv
// Pipeline sequencing controller: hazard/memory/halt inputs -> stage enables and bubbles, halt drain, perf counters.
// Latency: enables/flushes combinational in the same cycle; state, counters, err and halted registered.
// Backpressure: an outstanding data-memory access freezes every stage until it is acknowledged.
module pipeline_ctrl #(
    parameter int CNT_W        = 32,
    parameter int DRAIN_CYCLES = 4,
    parameter int MEM_TIMEOUT  = 255
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [1:0]       hazard_op_i,
    input  logic             dmem_req_i,
    input  logic             dmem_ack_i,
    input  logic             halt_req_i,
    output logic             pc_en_o,
    output logic             if_id_en_o,
    output logic             id_ex_en_o,
    output logic             ex_mem_en_o,
    output logic             mem_wb_en_o,
    output logic             if_id_flush_o,
    output logic             id_ex_flush_o,
    output logic [1:0]       state_o,
    output logic             halted_o,
    output logic             err_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o,
    output logic [CNT_W-1:0] mem_wait_cnt_o
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_DRAIN    = 2'd2,
        ST_HALTED   = 2'd3
    } state_t;

    localparam logic [3:0]       DRAIN_LAST = 4'(DRAIN_CYCLES);
    localparam logic [7:0]       WAIT_LIMIT = 8'(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

    state_t           state_q, state_d;
    logic [3:0]       drain_q, drain_d, drain_inc;
    logic [7:0]       wait_q, wait_d, wait_inc;
    logic             err_q, err_d;
    logic             halted_q;
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q, mem_wait_cnt_q;

    logic memfreeze, op_flush, op_stall, op_none, active;
    logic dec_freeze, dec_flush, dec_stall, dec_drain, dec_normal;

    always_comb begin
        memfreeze  = dmem_req_i && !dmem_ack_i;
        op_flush   = (hazard_op_i == 2'd2);
        op_stall   = hazard_op_i[0];
        op_none    = (hazard_op_i == 2'd0);
        active     = (state_q != ST_HALTED);
        dec_freeze = active && memfreeze;
        dec_flush  = active && !memfreeze && op_flush;
        dec_stall  = active && !memfreeze && op_stall;
        // Outside a stall/flush, DRAIN keeps the back end moving but feeds bubbles into IF/ID.
        dec_drain  = (state_q == ST_DRAIN) && !memfreeze && op_none;
        dec_normal = active && (state_q != ST_DRAIN) && !memfreeze && op_none;
    end

    always_comb begin
        pc_en_o       = rst_ni && (dec_flush || dec_normal);
        if_id_en_o    = rst_ni && (dec_flush || dec_normal || dec_drain);
        id_ex_en_o    = rst_ni && active && !memfreeze;
        ex_mem_en_o   = rst_ni && active && !memfreeze;
        mem_wb_en_o   = rst_ni && active && !memfreeze;
        if_id_flush_o = rst_ni && (dec_flush || dec_drain);
        id_ex_flush_o = rst_ni && (dec_flush || dec_stall);
    end

    always_comb begin
        state_d   = state_q;
        drain_d   = drain_q;
        wait_d    = wait_q;
        err_d     = err_q;
        drain_inc = drain_q + 4'd1;
        wait_inc  = wait_q + 8'd1;
        case (state_q)
            ST_RUN: begin
                wait_d = 8'd0;
                if (memfreeze) begin
                    state_d = ST_MEM_WAIT;
                end else if (halt_req_i && op_none) begin
                    state_d = ST_DRAIN;
                    drain_d = 4'd0;
                end
            end
            ST_MEM_WAIT: begin
                if (memfreeze) begin
                    wait_d = wait_inc;
                    if (wait_inc >= WAIT_LIMIT) begin
                        err_d   = 1'b1;
                        state_d = ST_HALTED;
                    end
                end else begin
                    wait_d  = 8'd0;
                    state_d = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (memfreeze) begin
                    wait_d = wait_inc;
                    if (wait_inc >= WAIT_LIMIT) begin
                        err_d   = 1'b1;
                        state_d = ST_HALTED;
                    end
                end else begin
                    if (dmem_ack_i) begin
                        wait_d = 8'd0;
                    end
                    // A taken older branch means the halt sat on the wrong path.
                    if (op_flush) begin
                        wait_d  = 8'd0;
                        state_d = ST_RUN;
                    end else if (!op_stall) begin
                        drain_d = drain_inc;
                        if (drain_inc == DRAIN_LAST) begin
                            state_d = ST_HALTED;
                        end
                    end
                end
            end
            ST_HALTED: begin
                state_d = ST_HALTED;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ST_RUN;
            drain_q  <= 4'd0;
            wait_q   <= 8'd0;
            err_q    <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            drain_q  <= drain_d;
            wait_q   <= wait_d;
            err_q    <= err_d;
            halted_q <= (state_d == ST_HALTED);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_cnt_q    <= '0;
            flush_cnt_q    <= '0;
            mem_wait_cnt_q <= '0;
        end else begin
            if (dec_stall && (stall_cnt_q != CNT_MAX)) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
            if (dec_flush && (flush_cnt_q != CNT_MAX)) begin
                flush_cnt_q <= flush_cnt_q + 1'b1;
            end
            if (dec_freeze && (mem_wait_cnt_q != CNT_MAX)) begin
                mem_wait_cnt_q <= mem_wait_cnt_q + 1'b1;
            end
        end
    end

    assign state_o        = state_q;
    assign halted_o       = halted_q;
    assign err_o          = err_q;
    assign stall_cnt_o    = stall_cnt_q;
    assign flush_cnt_o    = flush_cnt_q;
    assign mem_wait_cnt_o = mem_wait_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: two instances (default, and short-timeout/4-bit counters) share one stimulus stream.
module tb_pipeline_ctrl;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic [1:0] hazard_op_i;
    logic       dmem_req_i, dmem_ack_i, halt_req_i;

    always #5 clk_i = ~clk_i;

    logic        a_pc_en, a_if_id_en, a_id_ex_en, a_ex_mem_en, a_mem_wb_en, a_if_id_flush, a_id_ex_flush;
    logic [1:0]  a_state;
    logic        a_halted, a_err;
    logic [31:0] a_stall, a_flush, a_mw;

    logic        b_pc_en, b_if_id_en, b_id_ex_en, b_ex_mem_en, b_mem_wb_en, b_if_id_flush, b_id_ex_flush;
    logic [1:0]  b_state;
    logic        b_halted, b_err;
    logic [3:0]  b_stall, b_flush, b_mw;

    pipeline_ctrl u_dut_a (
        .clk_i(clk_i), .rst_ni(rst_ni), .hazard_op_i(hazard_op_i),
        .dmem_req_i(dmem_req_i), .dmem_ack_i(dmem_ack_i), .halt_req_i(halt_req_i),
        .pc_en_o(a_pc_en), .if_id_en_o(a_if_id_en), .id_ex_en_o(a_id_ex_en),
        .ex_mem_en_o(a_ex_mem_en), .mem_wb_en_o(a_mem_wb_en),
        .if_id_flush_o(a_if_id_flush), .id_ex_flush_o(a_id_ex_flush),
        .state_o(a_state), .halted_o(a_halted), .err_o(a_err),
        .stall_cnt_o(a_stall), .flush_cnt_o(a_flush), .mem_wait_cnt_o(a_mw)
    );

    pipeline_ctrl #(.CNT_W(4), .DRAIN_CYCLES(4), .MEM_TIMEOUT(3)) u_dut_b (
        .clk_i(clk_i), .rst_ni(rst_ni), .hazard_op_i(hazard_op_i),
        .dmem_req_i(dmem_req_i), .dmem_ack_i(dmem_ack_i), .halt_req_i(halt_req_i),
        .pc_en_o(b_pc_en), .if_id_en_o(b_if_id_en), .id_ex_en_o(b_id_ex_en),
        .ex_mem_en_o(b_ex_mem_en), .mem_wb_en_o(b_mem_wb_en),
        .if_id_flush_o(b_if_id_flush), .id_ex_flush_o(b_id_ex_flush),
        .state_o(b_state), .halted_o(b_halted), .err_o(b_err),
        .stall_cnt_o(b_stall), .flush_cnt_o(b_flush), .mem_wait_cnt_o(b_mw)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model, one slot per instance. Modes: 0 run, 1 mem wait, 2 drain, 3 halted.
    localparam int DC = 4;
    int     to_lim[2] = '{255, 3};
    longint cmax[2]   = '{64'hFFFF_FFFF, 64'd15};
    int     m_st[2], m_drain[2], m_wait[2];
    bit     m_err[2];
    longint m_stall[2], m_flush[2], m_mw[2];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected {pc, if_id, id_ex, ex_mem, mem_wb, if_id_flush, id_ex_flush}.
    function automatic logic [6:0] exp_dec(input int st, input logic [1:0] op, input logic req, input logic ack);
        if (st == 3)       return 7'b0000000;
        if (req && !ack)   return 7'b0000000;
        if (op == 2'd2)    return 7'b1111111;
        if (op != 2'd0)    return 7'b0011101;
        if (st == 2)       return 7'b0111110;
        return 7'b1111100;
    endfunction

    function automatic longint sat_inc(input longint v, input longint mx);
        return (v < mx) ? v + 1 : v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_st[i] = 0; m_drain[i] = 0; m_wait[i] = 0; m_err[i] = 1'b0;
            m_stall[i] = 0; m_flush[i] = 0; m_mw[i] = 0;
        end
    endtask

    task automatic model_step(input logic [1:0] op, input logic req, input logic ack, input logic halt);
        bit frz;
        frz = req && !ack;
        for (int i = 0; i < 2; i++) begin
            if (m_st[i] == 3) continue;
            if (frz)            m_mw[i]    = sat_inc(m_mw[i], cmax[i]);
            else if (op == 2)   m_flush[i] = sat_inc(m_flush[i], cmax[i]);
            else if (op != 0)   m_stall[i] = sat_inc(m_stall[i], cmax[i]);
            if (m_st[i] == 0) begin
                m_wait[i] = 0;
                if (frz) m_st[i] = 1;
                else if (halt && op == 0) begin m_st[i] = 2; m_drain[i] = 0; end
            end else if (frz) begin
                m_wait[i]++;
                if (m_wait[i] >= to_lim[i]) begin m_err[i] = 1'b1; m_st[i] = 3; end
            end else if (m_st[i] == 1) begin
                m_wait[i] = 0; m_st[i] = 0;
            end else begin
                if (ack) m_wait[i] = 0;
                if (op == 2) begin m_st[i] = 0; m_wait[i] = 0; end
                else if (op == 0) begin
                    m_drain[i]++;
                    if (m_drain[i] == DC) m_st[i] = 3;
                end
            end
        end
    endtask

    task automatic sample_dec(input logic [1:0] op, input logic req, input logic ack);
        chk("a_dec", {a_pc_en, a_if_id_en, a_id_ex_en, a_ex_mem_en, a_mem_wb_en, a_if_id_flush, a_id_ex_flush},
            exp_dec(m_st[0], op, req, ack));
        chk("b_dec", {b_pc_en, b_if_id_en, b_id_ex_en, b_ex_mem_en, b_mem_wb_en, b_if_id_flush, b_id_ex_flush},
            exp_dec(m_st[1], op, req, ack));
    endtask

    task automatic sample_regs();
        chk("a_state", a_state, m_st[0]);     chk("b_state", b_state, m_st[1]);
        chk("a_halted", a_halted, m_st[0] == 3); chk("b_halted", b_halted, m_st[1] == 3);
        chk("a_err", a_err, m_err[0]);        chk("b_err", b_err, m_err[1]);
        chk("a_stall", a_stall, m_stall[0]);  chk("b_stall", b_stall, m_stall[1]);
        chk("a_flush", a_flush, m_flush[0]);  chk("b_flush", b_flush, m_flush[1]);
        chk("a_mw", a_mw, m_mw[0]);           chk("b_mw", b_mw, m_mw[1]);
    endtask

    // Entered at posedge+1; inputs held for one full cycle, checked just before the next edge.
    task automatic cycle(input logic [1:0] op, input logic req, input logic ack, input logic halt);
        hazard_op_i = op; dmem_req_i = req; dmem_ack_i = ack; halt_req_i = halt;
        #3;
        sample_dec(op, req, ack);
        sample_regs();
        model_step(op, req, ack, halt);
        @(posedge clk_i);
        #1;
    endtask

    // Asserts reset asynchronously mid-cycle; enables must drop even with a "normal" input pattern.
    task automatic do_reset();
        hazard_op_i = 2'd0; dmem_req_i = 1'b0; dmem_ack_i = 1'b0; halt_req_i = 1'b0;
        rst_ni = 1'b0;
        model_reset();
        #1;
        chk("rst_a_dec", {a_pc_en, a_if_id_en, a_id_ex_en, a_ex_mem_en, a_mem_wb_en, a_if_id_flush, a_id_ex_flush}, 7'd0);
        chk("rst_b_dec", {b_pc_en, b_if_id_en, b_id_ex_en, b_ex_mem_en, b_mem_wb_en, b_if_id_flush, b_id_ex_flush}, 7'd0);
        sample_regs();
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        logic [1:0] r_op;
        logic       r_req, r_ack, r_halt;
        int         r;

        do_reset();

        // Data stall for three cycles.
        repeat (3) cycle(2'd1, 1'b0, 1'b0, 1'b0);
        chk("stall_cnt_3", a_stall, 3);
        chk("stall_state_run", a_state, 0);

        // Single branch flush.
        cycle(2'd2, 1'b0, 1'b0, 1'b0);
        chk("flush_cnt_1", a_flush, 1);

        // Memory freeze for five cycles with a stall pending, then ack.
        repeat (5) cycle(2'd1, 1'b1, 1'b0, 1'b0);
        chk("freeze_stall_held", a_stall, 3);
        cycle(2'd1, 1'b1, 1'b1, 1'b0);
        chk("mw_cnt_5", a_mw, 5);
        chk("ack_stall_applied", a_stall, 4);
        chk("ack_state_run", a_state, 0);

        // Plain halt drain.
        do_reset();
        cycle(2'd0, 1'b0, 1'b0, 1'b1);
        repeat (3) cycle(2'd0, 1'b0, 1'b0, 1'b1);
        chk("drain3_not_halted", a_halted, 0);
        chk("drain3_state", a_state, 2);
        cycle(2'd0, 1'b0, 1'b0, 1'b1);
        chk("drain4_halted", a_halted, 1);
        chk("drain4_state", a_state, 3);
        cycle(2'd1, 1'b1, 1'b0, 1'b1);
        chk("halted_no_count", a_stall, 0);

        // Drain with one stall: HALTED one cycle later.
        do_reset();
        cycle(2'd0, 1'b0, 1'b0, 1'b1);
        repeat (2) cycle(2'd0, 1'b0, 1'b0, 1'b1);
        cycle(2'd1, 1'b0, 1'b0, 1'b1);
        cycle(2'd0, 1'b0, 1'b0, 1'b1);
        chk("stalldrain_not_halted", a_halted, 0);
        cycle(2'd0, 1'b0, 1'b0, 1'b1);
        chk("stalldrain_halted", a_halted, 1);

        // Wrong-path halt cancelled by a taken branch.
        do_reset();
        cycle(2'd0, 1'b0, 1'b0, 1'b1);
        cycle(2'd0, 1'b0, 1'b0, 1'b1);
        cycle(2'd2, 1'b0, 1'b0, 1'b1);
        chk("cancel_state_run", a_state, 0);
        repeat (6) cycle(2'd0, 1'b0, 1'b0, 1'b0);
        chk("cancel_not_halted", a_halted, 0);

        // Memory timeout on the short-timeout instance, then async reset.
        do_reset();
        repeat (5) cycle(2'd0, 1'b1, 1'b0, 1'b0);
        chk("timeout_err", b_err, 1);
        chk("timeout_halted", b_state, 3);
        chk("long_wait_no_err", a_err, 0);
        #2;
        do_reset();
        chk("arst_err", b_err, 0);
        chk("arst_state", b_state, 0);

        // Counter saturation on the 4-bit instance.
        repeat (20) cycle(2'd3, 1'b0, 1'b0, 1'b0);
        chk("sat_b_stall", b_stall, 15);
        chk("nosat_a_stall", a_stall, 20);

        // Randomized traffic with periodic resets.
        for (int k = 0; k < 800; k++) begin
            if (k % 60 == 59) do_reset();
            r      = $urandom_range(0, 9);
            r_op   = (r < 6) ? 2'd0 : (r < 8) ? 2'd1 : (r == 8) ? 2'd2 : 2'd3;
            r_req  = ($urandom_range(0, 3) == 0);
            r_ack  = r_req ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 7) == 0);
            r_halt = ($urandom_range(0, 5) == 0);
            cycle(r_op, r_req, r_ack, r_halt);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
